// File: rtl/md5_command_receiver.sv
// md5_command_receiver: packs 4 UART bytes into a 32-bit word and emits a setup-safe, stretched hasReceived strobe
// Ports: clk/reset (async, active-low) | rxData/rxValid: UART byte stream
//        dataOut: assembled word | hasReceived: word strobe (used as a clock downstream)
//        overrun/timedOut: sticky error flags | clearFlags: synchronous flag clear
module md5_command_receiver #(
    parameter int MSB_FIRST      = 1,
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    input  logic        clearFlags,
    output logic [31:0] dataOut,
    output logic        hasReceived,
    output logic        overrun,
    output logic        timedOut
);
    localparam int TW   = $clog2(TIMEOUT_CYCLES);
    localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, GAP} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [1:0]     idx, lane;
    logic [TW-1:0]  timer;
    logic [31:0]    asm_word, word, pend_word, load_word;
    logic           pend_valid, word_done, timeout, load, take_new, pop, store, drop;

    assign lane      = (MSB_FIRST != 0) ? ~idx : idx;
    assign word_done = rxValid && idx == 2'd3;
    // an arriving byte always beats the timeout in the same cycle
    assign timeout   = !rxValid && idx != 2'd0 && timer == TW'(TIMEOUT_CYCLES - 1);

    // completed word including the byte arriving this cycle
    always_comb begin
        word = asm_word;
        word[{lane, 3'b000} +: 8] = rxData;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        load_word  = word;
        take_new   = 1'b0;
        pop        = 1'b0;
        case (state)
            SETUP: begin
                state_next = HIGH;
                cnt_next   = '0;
            end
            HIGH: begin
                state_next = (cnt == CW'(PULSE_CYCLES - 1)) ? GAP : HIGH;
                cnt_next   = (cnt == CW'(PULSE_CYCLES - 1)) ? '0 : cnt + 1'b1;
            end
            GAP: begin
                state_next = (cnt == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
                cnt_next   = (cnt == CW'(GAP_CYCLES - 1)) ? '0 : cnt + 1'b1;
            end
            default: ;
        endcase
        // new work may start from IDLE or from the final GAP cycle; pending is older, so it goes first
        if (state == IDLE || (state == GAP && cnt == CW'(GAP_CYCLES - 1))) begin
            if (pend_valid) begin
                load       = 1'b1;
                pop        = 1'b1;
                load_word  = pend_word;
                state_next = SETUP;
            end else if (word_done) begin
                load       = 1'b1;
                take_new   = 1'b1;
                state_next = SETUP;
            end
        end
    end

    assign store = word_done && !take_new;
    assign drop  = store && pend_valid && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            timer       <= '0;
            asm_word    <= '0;
            dataOut     <= '0;
            hasReceived <= 1'b0;
            pend_valid  <= 1'b0;
            pend_word   <= '0;
            overrun     <= 1'b0;
            timedOut    <= 1'b0;
        end else begin
            if (rxValid) begin
                asm_word[{lane, 3'b000} +: 8] <= rxData;
                idx   <= idx + 1'b1;
                timer <= '0;
            end else if (timeout) begin
                asm_word <= '0;
                idx      <= '0;
                timer    <= '0;
            end else begin
                timer <= (idx != 2'd0) ? timer + 1'b1 : '0;
            end
            state <= state_next;
            cnt   <= cnt_next;
            if (load)
                dataOut <= load_word;
            // registered from next state so the strobe is glitch-free
            hasReceived <= (state_next == HIGH);
            pend_valid  <= (pend_valid && !pop) || store;
            if (store && !drop)
                pend_word <= word;
            overrun  <= drop | (overrun & ~clearFlags);
            timedOut <= timeout | (timedOut & ~clearFlags);
        end
    end
endmodule

// File: tb/tb_md5_command_receiver.sv
// tb_md5_command_receiver: directed checks of word assembly, pulse timing, buffering, timeout and reset
module tb_md5_command_receiver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxValid = 1'b0;
    logic        clearFlags = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic [31:0] do_a, do_b;
    logic        hr_a, hr_b, ov_a, ov_b, to_a, to_b;

    always #5 clk = ~clk;

    md5_command_receiver #(.MSB_FIRST(1), .PULSE_CYCLES(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .reset(reset), .rxData(rxData), .rxValid(rxValid), .clearFlags(clearFlags),
        .dataOut(do_a), .hasReceived(hr_a), .overrun(ov_a), .timedOut(to_a));

    md5_command_receiver #(.MSB_FIRST(0), .PULSE_CYCLES(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .reset(reset), .rxData(rxData), .rxValid(rxValid), .clearFlags(clearFlags),
        .dataOut(do_b), .hasReceived(hr_b), .overrun(ov_b), .timedOut(to_b));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // pulse monitor on dut_a: records dataOut at each rising strobe and the low time before it
    logic        prev = 1'b0;
    int          lowrun = 0;
    logic [31:0] words[$];
    int          gaps[$];
    always @(posedge clk) begin
        if (hr_a && !prev) begin
            words.push_back(do_a);
            gaps.push_back(lowrun);
        end
        lowrun = hr_a ? 0 : lowrun + 1;
        prev = hr_a;
    end

    task automatic byte_in(input logic [7:0] b);
        rxData = b;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0][7:0] b;
        int              sp;
        logic [31:0]     ea;
        logic [31:0]     eb;
    } vec_t;

    vec_t vt[4];
    logic [7:0] bb[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, base2, w;
        logic held;
        vt[0] = '{{8'h52, 8'h30, 8'h00, 8'h01}, 10, 32'h52300001, 32'h01003052};
        vt[1] = '{{8'h01, 8'h00, 8'h30, 8'h52}, 10, 32'h01003052, 32'h52300001};
        vt[2] = '{{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0, 32'hDEADBEEF, 32'hEFBEADDE};
        vt[3] = '{{8'hFF, 8'h00, 8'hFF, 8'h01}, 3, 32'hFF00FF01, 32'h01FF00FF};
        bb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

        idle(2);
        chk("rst_dataOut", do_a, 32'h0);
        chk("rst_hasReceived", 32'(hr_a), 32'h0);
        chk("rst_overrun", 32'(ov_a), 32'h0);
        chk("rst_timedOut", 32'(to_a), 32'h0);
        reset = 1'b1;
        idle(2);

        for (int v = 0; v < 4; v++) begin
            for (int i = 3; i >= 0; i--) begin
                byte_in(vt[v].b[i]);
                if (i > 0) idle(vt[v].sp);
            end
            chk($sformatf("v%0d_setup_data_a", v), do_a, vt[v].ea);
            chk($sformatf("v%0d_setup_data_b", v), do_b, vt[v].eb);
            chk($sformatf("v%0d_setup_low", v), 32'(hr_a), 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_rise", v), 32'(hr_a), 32'h1);
            w = 0;
            held = 1'b1;
            while (hr_a && w < 10) begin
                if (do_a !== vt[v].ea) held = 1'b0;
                w++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_width", v), 32'(w), 32'd4);
            chk($sformatf("v%0d_held", v), 32'(held), 32'h1);
            chk($sformatf("v%0d_overrun", v), 32'(ov_a), 32'h0);
            chk($sformatf("v%0d_timedOut", v), 32'(to_a), 32'h0);
            idle(6);
        end

        // partial word abandoned by timeout, then a clean word
        base = words.size();
        byte_in(8'hAA);
        byte_in(8'hBB);
        idle(20);
        chk("to_no_pulse", 32'(words.size() - base), 32'd0);
        chk("to_flag_a", 32'(to_a), 32'h1);
        chk("to_flag_b", 32'(to_b), 32'h1);
        byte_in(8'h52);
        byte_in(8'h30);
        byte_in(8'h10);
        byte_in(8'h00);
        idle(12);
        chk("to_pulses", 32'(words.size() - base), 32'd1);
        if (words.size() > base) chk("to_word", words[base], 32'h52301000);

        // three words back to back: one pulses, one pends, one drops
        base = words.size();
        for (int i = 0; i < 12; i++) begin
            rxData = bb[i];
            rxValid = 1'b1;
            @(negedge clk);
        end
        rxValid = 1'b0;
        chk("b2b_overrun_a", 32'(ov_a), 32'h1);
        chk("b2b_overrun_b", 32'(ov_b), 32'h1);
        idle(40);
        chk("b2b_pulses", 32'(words.size() - base), 32'd2);
        if (words.size() >= base + 2) begin
            chk("b2b_word1", words[base], 32'h11223344);
            chk("b2b_word2", words[base + 1], 32'h55667788);
            chk("b2b_gap", 32'(gaps[base + 1] >= 4), 32'h1);
        end

        // clearFlags racing a fresh overrun: set wins
        for (int i = 0; i < 12; i++) begin
            rxData = bb[i];
            rxValid = 1'b1;
            clearFlags = (i == 11);
            @(negedge clk);
        end
        rxValid = 1'b0;
        clearFlags = 1'b0;
        chk("race_overrun", 32'(ov_a), 32'h1);
        chk("race_timedOut_cleared", 32'(to_a), 32'h0);
        clearFlags = 1'b1;
        @(negedge clk);
        clearFlags = 1'b0;
        chk("clear_overrun", 32'(ov_a), 32'h0);
        idle(40);

        // reset during the second HIGH cycle, with a partial word in flight
        byte_in(8'hCA);
        byte_in(8'hFE);
        byte_in(8'hF0);
        byte_in(8'h0D);
        byte_in(8'hDE);
        byte_in(8'hAD);
        chk("pre_rst_high", 32'(hr_a), 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_async_hr_a", 32'(hr_a), 32'h0);
        chk("rst_async_hr_b", 32'(hr_b), 32'h0);
        chk("rst_async_data", do_a, 32'h0);
        idle(2);
        reset = 1'b1;
        idle(2);
        base2 = words.size();
        byte_in(8'h01);
        byte_in(8'h02);
        byte_in(8'h03);
        byte_in(8'h04);
        chk("post_rst_data_a", do_a, 32'h01020304);
        chk("post_rst_data_b", do_b, 32'h04030201);
        idle(12);
        chk("post_rst_pulses", 32'(words.size() - base2), 32'd1);
        if (words.size() > base2) chk("post_rst_word", words[base2], 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
